// File: rtl/bin_gray_cnt_pkg.sv
// -----------------------------------------------------------------------------
// bin_gray_cnt_pkg
// Shared definitions for the binary/gray counter family (bin_gray_cnt encoder
// and gray_bin decoder).
//   GRAY_W      : default code width used by the lab design
//   GRAY_MAX_W  : widest code supported; gray_enc operates at this width
//   gray_enc()  : binary-to-gray conversion, x XOR (x >> 1), logical shift.
//                 Callers zero-extend narrower values to GRAY_MAX_W and keep
//                 the low WIDTH bits of the result. Zero upper bits make this
//                 identical to a WIDTH-bit encode.
// -----------------------------------------------------------------------------
package bin_gray_cnt_pkg;

    localparam int GRAY_W     = 4;
    localparam int GRAY_MAX_W = 16;

    function automatic logic [GRAY_MAX_W-1:0] gray_enc(input logic [GRAY_MAX_W-1:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage : bin_gray_cnt_pkg

// File: rtl/gray_bin.sv
// -----------------------------------------------------------------------------
// gray_bin
// Gray-to-binary decoder (combinational).
//   a : gray-coded input, WIDTH bits
//   c : binary value, c[i] = XOR of a[WIDTH-1:i]
// -----------------------------------------------------------------------------
module gray_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] dec_s;
    logic             acc_s;

    // Running XOR from the MSB down gives each binary bit.
    always_comb begin
        dec_s = {WIDTH{1'b0}};
        acc_s = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc_s    = acc_s ^ a[i];
            dec_s[i] = acc_s;
        end
    end

    assign c = dec_s;

endmodule : gray_bin

// File: rtl/bin_gray_cnt.sv
// -----------------------------------------------------------------------------
// bin_gray_cnt
// Registered binary up/down counter with a gray-coded output.
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset (clears everything)
//   en       : count enable, one step per cycle while high
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous load strobe (beats en)
//   load_bin : binary value to load
//   bin_q    : registered binary count
//   gray_q   : registered gray code of bin_q
//   wrap     : one-cycle pulse, the last step wrapped around
//   flip     : one-hot gray bit that toggled on the last step, zero otherwise
// Priority at each edge: rst > load > en > hold.
// -----------------------------------------------------------------------------
module bin_gray_cnt
    import bin_gray_cnt_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap,
    output logic [WIDTH-1:0] flip
);

    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      bin_r;
    logic [WIDTH-1:0]      gray_r;
    logic                  wrap_r;
    logic [WIDTH-1:0]      flip_r;

    logic [WIDTH-1:0]      step_s;
    logic                  step_wrap_s;
    logic [WIDTH-1:0]      next_bin_s;
    logic [GRAY_MAX_W-1:0] next_gray_full_s;
    logic [WIDTH-1:0]      next_gray_s;
    logic                  next_wrap_s;
    logic [WIDTH-1:0]      next_flip_s;

    // One counting step in the sampled direction; the carry/borrow out is
    // dropped, and the wrap flag is read from the end-of-range value instead.
    always_comb begin
        step_s      = bin_r;
        step_wrap_s = 1'b0;
        if (up) begin
            step_s      = bin_r + ONE_V;
            step_wrap_s = (bin_r == ONES_V);
        end else begin
            step_s      = bin_r - ONE_V;
            step_wrap_s = (bin_r == ZERO_V);
        end
    end

    // Next-state selection: load beats count beats hold; wrap/flip only on a count.
    always_comb begin
        next_bin_s  = bin_r;
        next_wrap_s = 1'b0;
        next_flip_s = ZERO_V;
        if (load) begin
            next_bin_s  = load_bin;
            next_wrap_s = 1'b0;
            next_flip_s = ZERO_V;
        end else if (en) begin
            next_bin_s  = step_s;
            next_wrap_s = step_wrap_s;
            next_flip_s = gray_r ^ next_gray_s;
        end else begin
            next_bin_s  = bin_r;
            next_wrap_s = 1'b0;
            next_flip_s = ZERO_V;
        end
    end

    // Gray code of the next binary value (shared encoder, narrowed to WIDTH).
    always_comb begin
        next_gray_full_s = gray_enc(GRAY_MAX_W'(next_bin_s));
        next_gray_s      = next_gray_full_s[WIDTH-1:0];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= ZERO_V;
            gray_r <= ZERO_V;
            wrap_r <= 1'b0;
            flip_r <= ZERO_V;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            wrap_r <= next_wrap_s;
            flip_r <= next_flip_s;
        end
    end

    assign bin_q  = bin_r;
    assign gray_q = gray_r;
    assign wrap   = wrap_r;
    assign flip   = flip_r;

endmodule : bin_gray_cnt

// File: tb/tb_bin_gray_cnt.sv
// -----------------------------------------------------------------------------
// tb_bin_gray_cnt
// Directed and randomized checks of bin_gray_cnt (WIDTH = 4) against an
// arithmetic reference model, plus a round trip through gray_bin.
// -----------------------------------------------------------------------------
module tb_bin_gray_cnt;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = 4'd0;
    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap;
    logic [W-1:0] flip;
    logic [W-1:0] dec_c;

    int total = 0;
    int bad = 0;

    // Reference model state (plain integers).
    int m_bin  = 0;
    int m_wrap = 0;
    int m_flip = 0;

    // Expected gray sequence for a full up sweep from 0.
    localparam logic [3:0] GSEQ [0:16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
        4'b0000 };

    bin_gray_cnt #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin_q    (bin_q),
        .gray_q   (gray_q),
        .wrap     (wrap),
        .flip     (flip)
    );

    gray_bin #(.WIDTH(W)) u_dec (
        .a (gray_q),
        .c (dec_c)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int v);
        return (v ^ (v / 2)) % N;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare everything.
    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic l, input logic [W-1:0] lb);
        int old_g;
        rst = r; en = e; up = u; load = l; load_bin = lb;
        @(posedge clk);
        #1;
        old_g = gray_of(m_bin);
        if (r) begin
            m_bin = 0; m_wrap = 0; m_flip = 0;
        end else if (l) begin
            m_bin = int'(lb); m_wrap = 0; m_flip = 0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin + 1 >= N) ? 1 : 0;
                m_bin  = (m_bin + 1) % N;
            end else begin
                m_wrap = (m_bin == 0) ? 1 : 0;
                m_bin  = (m_bin + N - 1) % N;
            end
            m_flip = gray_of(m_bin) ^ old_g;
        end else begin
            m_wrap = 0; m_flip = 0;
        end
        chk("bin_q",  int'(bin_q),  m_bin);
        chk("gray_q", int'(gray_q), gray_of(m_bin));
        chk("wrap",   int'(wrap),   m_wrap);
        chk("flip",   int'(flip),   m_flip);
        chk("round_trip", int'(dec_c), int'(bin_q));
        if (!r && !l && e) begin
            chk("flip_onehot", int'($onehot(flip)), 1);
        end
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        chk("rst_bin", int'(bin_q), 0);
        chk("rst_gray", int'(gray_q), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_flip", int'(flip), 0);

        // Full up sweep against the known gray sequence
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            chk("up_seq", int'(gray_q), int'(GSEQ[i]));
            chk("up_wrap", int'(wrap), (i == 16) ? 1 : 0);
        end
        chk("wrap_flip", int'(flip), 8);

        // Down from zero wraps to all-ones
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn_bin", int'(bin_q), 15);
        chk("dn_gray", int'(gray_q), 8);
        chk("dn_wrap", int'(wrap), 1);
        chk("dn_flip", int'(flip), 8);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn2_bin", int'(bin_q), 14);
        chk("dn2_gray", int'(gray_q), 9);
        chk("dn2_wrap", int'(wrap), 0);
        chk("dn2_flip", int'(flip), 1);

        // Load wins over en
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101);
        chk("ld_bin", int'(bin_q), 5);
        chk("ld_gray", int'(gray_q), 7);
        chk("ld_wrap", int'(wrap), 0);
        chk("ld_flip", int'(flip), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("ld_up_bin", int'(bin_q), 6);
        chk("ld_up_gray", int'(gray_q), 5);
        chk("ld_up_flip", int'(flip), 2);

        // Up-then-down returns, same flip bit both times
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("ud_flip_a", int'(flip), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("ud_bin", int'(bin_q), 6);
        chk("ud_flip_b", int'(flip), 1);

        // Count to 10, then reset mid-count with en high
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("pre_rst_bin", int'(bin_q), 10);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("mid_rst_bin", int'(bin_q), 0);
        chk("mid_rst_gray", int'(gray_q), 0);
        chk("mid_rst_wrap", int'(wrap), 0);
        chk("mid_rst_flip", int'(flip), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        chk("post_rst_bin", int'(bin_q), 1);

        // Round trip over a full up sweep and a full down sweep
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Hold for 5 cycles at 0011
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            chk("hold_bin", int'(bin_q), 3);
            chk("hold_gray", int'(gray_q), 2);
            chk("hold_wrap", int'(wrap), 0);
            chk("hold_flip", int'(flip), 0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(1, 0)),
                ($urandom_range(7, 0) == 0) ? 1'b1 : 1'b0,
                4'($urandom_range(15, 0)));
        end

        // Continuous en: exactly one wrap per 16 steps in each direction
        begin
            int wraps;
            wraps = 0;
            for (int i = 0; i < 32; i++) begin
                cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
                wraps += int'(wrap);
            end
            chk("wrap_count_up", wraps, 2);
            wraps = 0;
            for (int i = 0; i < 32; i++) begin
                cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
                wraps += int'(wrap);
            end
            chk("wrap_count_dn", wraps, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bin_gray_cnt
